// File: rtl/trigger_idle_monitor_pkg.sv
// Shared trigger/monitor types.
// Monitor FSM encoding and statistics width.
package TriggerTypes;

  typedef enum logic [1:0] {
    MON_RUN   = 2'd0,
    MON_COUNT = 2'd1,
    MON_IDLE  = 2'd2
  } monitor_state_t;

  localparam int MON_STATS_W = 32;

endpackage

// File: rtl/trigger_idle_monitor_quiet_reducer.sv
// Combinational quiescence reduction over
// all triggers, FIFOs and the external agent.
module quiet_reducer #(
  parameter int NUM_TRIGGERS = 4,
  parameter int NUM_FIFOS    = 4
) (
  input  logic                    monitor_enable,
  input  logic [NUM_TRIGGERS-1:0] trigger_sleeping,
  input  logic [NUM_TRIGGERS-1:0] trigger_idle,
  input  logic [NUM_FIFOS-1:0]    fifo_activity,
  input  logic                    ext_busy,
  output logic                    quiet
);

  // Every trigger parked, no FIFO traffic, nothing external in flight
  assign quiet = monitor_enable
               & ~ext_busy
               & ~|fifo_activity
               & &(trigger_sleeping | trigger_idle);

endmodule

// File: rtl/trigger_idle_monitor.sv
// Network idle monitor: declares idle after a quiet window.
// Optional idle-event counter: TRIGGER_MONITOR_STATS_EN.
module trigger_idle_monitor
  import TriggerTypes::*;
#(
  parameter int NUM_TRIGGERS = 4,
  parameter int NUM_FIFOS    = 4,
  parameter int QUIET_CYCLES = 8,
  parameter int CNT_W        = $clog2(QUIET_CYCLES + 1)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    monitor_enable,
  input  logic [NUM_TRIGGERS-1:0] trigger_sleeping,
  input  logic [NUM_TRIGGERS-1:0] trigger_idle,
  input  logic [NUM_FIFOS-1:0]    fifo_activity,
  input  logic                    ext_busy,
  output logic                    network_idle,
  output logic [CNT_W-1:0]        quiet_count,
  output logic [MON_STATS_W-1:0]  idle_events
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic           quiet;
  monitor_state_t state_q;
  monitor_state_t state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  quiet_reducer #(
    .NUM_TRIGGERS (NUM_TRIGGERS),
    .NUM_FIFOS    (NUM_FIFOS)
  ) u_quiet (
    .monitor_enable   (monitor_enable),
    .trigger_sleeping (trigger_sleeping),
    .trigger_idle     (trigger_idle),
    .fifo_activity    (fifo_activity),
    .ext_busy         (ext_busy),
    .quiet            (quiet)
  );

  // Next state and quiet counter; any activity returns to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MON_RUN: begin
        if (!quiet) begin
          cnt_d = '0;
        end else if (QUIET_CYCLES == 1) begin
          state_d = MON_IDLE;
          cnt_d   = CNT_MAX;
        end else begin
          state_d = MON_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      MON_COUNT: begin
        if (!quiet) begin
          state_d = MON_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = MON_IDLE;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      MON_IDLE: begin
        if (!quiet) begin
          state_d = MON_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_MAX;
        end
      end
      default: begin
        state_d = MON_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= MON_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Idle is gated by quiet so activity drops it in the same cycle
  assign network_idle = (state_q == MON_IDLE) & quiet;
  assign quiet_count  = cnt_q;

`ifdef TRIGGER_MONITOR_STATS_EN
  logic                   enter_idle;
  logic [MON_STATS_W-1:0] events_q;

  assign enter_idle = (state_q != MON_IDLE)
                    & (state_d == MON_IDLE);

  // Saturating count of RUN/COUNT -> IDLE transitions
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      events_q <= '0;
    end else if (enter_idle && events_q != '1) begin
      events_q <= events_q + 1'b1;
    end
  end

  assign idle_events = events_q;
`else
  assign idle_events = '0;
`endif

endmodule

// File: tb/tb_trigger_idle_monitor.sv
// Directed bench for trigger_idle_monitor.
// Two instances: QUIET_CYCLES=8 and QUIET_CYCLES=1.
module tb_trigger_idle_monitor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  slp;
  logic [3:0]  tidl;
  logic [3:0]  fifo;
  logic        busy;

  logic        idle8;
  logic [3:0]  qc8;
  logic [31:0] ev8;
  logic        idle1;
  logic [0:0]  qc1;
  logic [31:0] ev1;

  int checks;
  int errors;

  trigger_idle_monitor #(
    .NUM_TRIGGERS (4),
    .NUM_FIFOS    (4),
    .QUIET_CYCLES (8)
  ) dut8 (
    .ap_clk           (clk),
    .ap_rst_n         (rst_n),
    .monitor_enable   (en),
    .trigger_sleeping (slp),
    .trigger_idle     (tidl),
    .fifo_activity    (fifo),
    .ext_busy         (busy),
    .network_idle     (idle8),
    .quiet_count      (qc8),
    .idle_events      (ev8)
  );

  trigger_idle_monitor #(
    .NUM_TRIGGERS (4),
    .NUM_FIFOS    (4),
    .QUIET_CYCLES (1)
  ) dut1 (
    .ap_clk           (clk),
    .ap_rst_n         (rst_n),
    .monitor_enable   (en),
    .trigger_sleeping (slp),
    .trigger_idle     (tidl),
    .fifo_activity    (fifo),
    .ext_busy         (busy),
    .network_idle     (idle1),
    .quiet_count      (qc1),
    .idle_events      (ev1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int unsigned ev_exp;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    slp    = 4'b0000;
    tidl   = 4'b1111;
    fifo   = 4'b0000;
    busy   = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("rst_idle", {31'd0, idle8}, 0);
    check("rst_qc", {28'd0, qc8}, 0);
    check("rst_ev", ev8, 0);
    check("rst_idle1", {31'd0, idle1}, 0);
    rst_n = 1'b1;

    // Ramp from reset: idle after the 8th edge
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("ramp_qc%0d", k),
            {28'd0, qc8}, (k < 8) ? k : 8);
      check($sformatf("ramp_idle%0d", k),
            {31'd0, idle8}, (k >= 8) ? 1 : 0);
      if (k == 1) begin
        check("q1_qc", {31'd0, qc1}, 1);
        check("q1_idle", {31'd0, idle1}, 1);
      end
    end

    // Trigger 0 wakes for one cycle while idle
    tidl[0] = 1'b0;
    #1;
    check("wake_same", {31'd0, idle8}, 0);
    check("wake_same1", {31'd0, idle1}, 0);
    step();
    check("wake_qc", {28'd0, qc8}, 0);
    tidl[0] = 1'b1;
    #1;
    check("wake_run", {31'd0, idle8}, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("wake_idle%0d", k),
            {31'd0, idle8}, (k == 8) ? 1 : 0);
    end
    check("wake_qc8", {28'd0, qc8}, 8);

    // Knock back to RUN, 5 quiet, then fifo[2] pulse
    slp[1] = 1'b1;
    tidl[1] = 1'b0;
    #1;
    check("slp_ok", {31'd0, idle8}, 1);
    fifo = 4'b0001;
    step();
    fifo = 4'b0000;
    for (int k = 1; k <= 5; k++) step();
    check("five_qc", {28'd0, qc8}, 5);
    fifo[2] = 1'b1;
    #1;
    check("pulse_same", {31'd0, idle8}, 0);
    step();
    fifo[2] = 1'b0;
    check("pulse_qc", {28'd0, qc8}, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("pulse_idle%0d", k),
            {31'd0, idle8}, (k == 8) ? 1 : 0);
    end

`ifdef TRIGGER_MONITOR_STATS_EN
    ev_exp = 3;
`else
    ev_exp = 0;
`endif
    check("ev_three", ev8, ev_exp);

    // monitor_enable low drops idle at once
    en = 1'b0;
    #1;
    check("en_same", {31'd0, idle8}, 0);
    step();
    check("en_qc", {28'd0, qc8}, 0);
    en = 1'b1;

    // Activity on the threshold cycle wins
    for (int k = 1; k <= 7; k++) step();
    check("thr_qc7", {28'd0, qc8}, 7);
    busy = 1'b1;
    step();
    busy = 1'b0;
    check("thr_qc", {28'd0, qc8}, 0);
    check("thr_idle", {31'd0, idle8}, 0);
    for (int k = 1; k <= 10; k++) step();
    check("sat_qc", {28'd0, qc8}, 8);
    check("sat_idle", {31'd0, idle8}, 1);

`ifdef TRIGGER_MONITOR_STATS_EN
    ev_exp = 4;
`else
    ev_exp = 0;
`endif
    check("ev_four", ev8, ev_exp);

    // Asynchronous reset while idle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_idle", {31'd0, idle8}, 0);
    check("arst_qc", {28'd0, qc8}, 0);
    check("arst_ev", ev8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_run", {28'd0, qc8}, 1);
    check("arst_idle2", {31'd0, idle8}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
